// File: rtl/int_div_pipeline_core.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first.
// Optional macro INT_DIV_ZERO_FAST_EN: a zero divisor bypasses the RUN phase.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   req_i        start request, accepted in IDLE or DONE
//   a_i, b_i     unsigned dividend / divisor, captured on accept
//   quotient_o   registered floor(a/b), all-ones when b == 0
//   remainder_o  registered a mod b, a when b == 0
//   ack_o        one-cycle completion pulse, BITWIDTH+1 cycles after accept
module int_div_pipeline_core #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic [BITWIDTH-1:0] a_i,
  input  logic [BITWIDTH-1:0] b_i,
  output logic [BITWIDTH-1:0] quotient_o,
  output logic [BITWIDTH-1:0] remainder_o,
  output logic                ack_o
);

  localparam int unsigned W  = BITWIDTH;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  div_q, div_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rmd_q, rmd_d;
  logic          ack_q, ack_d;

  logic [W:0]    trial;
  logic [W-1:0]  diff;
  logic          take;
  logic          accept;
  logic          zero_fast;

`ifdef INT_DIV_ZERO_FAST_EN
  assign zero_fast = (b_i == '0);
`else
  assign zero_fast = 1'b0;
`endif

  // Partial remainder shifted left with the next dividend bit is W+1 bits
  // wide, so the compare never overflows; the stored remainder stays below
  // the divisor and therefore fits in W bits.
  assign trial = {rem_q, quo_q[W-1]};
  assign take  = (trial >= {1'b0, div_q});
  assign diff  = trial[W-1:0] - div_q;

  assign accept = req_i && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
      end
      RUN: begin
        // quo_q shifts dividend bits out at the top and
        // quotient bits in at the bottom.
        rem_d = take ? diff : trial[W-1:0];
        quo_d = {quo_q[W-2:0], take};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        quot_d  = quo_q;
        rmd_d   = rem_q;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new request overrides the DONE->IDLE return; the result above
    // is still published on the same edge.
    if (accept) begin
      rem_d   = '0;
      quo_d   = a_i;
      div_d   = b_i;
      cnt_d   = '0;
      state_d = RUN;
      if (zero_fast) begin
        quo_d   = '1;
        rem_d   = a_i;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      rmd_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      ack_q   <= ack_d;
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rmd_q;
  assign ack_o       = ack_q;

endmodule

// File: tb/tb_int_div_pipeline_core.sv
// Self-checking bench for int_div_pipeline_core.
// Transaction-level model checked every cycle plus directed literal checks.
module tb_int_div_pipeline_core;

  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef INT_DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = LAT;
`endif

  logic         clk = 1'b1;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         ack;

  always #5 clk = ~clk;

  int_div_pipeline_core #(.BITWIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .a_i         (a),
    .b_i         (b),
    .quotient_o  (q),
    .remainder_o (r),
    .ack_o       (ack)
  );

  int chk  = 0;
  int pass = 0;
  int e    = 0;

  task automatic check(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h at edge %0d", nm, act, exp, e);
  endtask

  function automatic logic [W-1:0] fq(input logic [W-1:0] x,
                                      input logic [W-1:0] y);
    return (y == '0) ? '1 : x / y;
  endfunction

  function automatic logic [W-1:0] fr(input logic [W-1:0] x,
                                      input logic [W-1:0] y);
    return (y == '0) ? x : x % y;
  endfunction

  // Model: one operation in flight, finishing at a known edge.
  logic         m_pend = 1'b0;
  int           m_done = 0;
  logic [W-1:0] m_pq   = '0;
  logic [W-1:0] m_pr   = '0;
  logic [W-1:0] m_q    = '0;
  logic [W-1:0] m_r    = '0;
  logic         m_ack  = 1'b0;

  always @(posedge clk) e <= e + 1;

  always @(negedge clk) begin
    int n;
    if (e > 0) begin
      check("m_ack", {31'b0, ack}, {31'b0, m_ack});
      check("m_quot", q, m_q);
      check("m_rem", r, m_r);
    end
    n = e + 1;
    m_ack = 1'b0;
    if (rst) begin
      m_pend = 1'b0;
      m_q = '0;
      m_r = '0;
    end else begin
      if (m_pend && n == m_done) begin
        m_ack  = 1'b1;
        m_q    = m_pq;
        m_r    = m_pr;
        m_pend = 1'b0;
      end
      if (req && !m_pend) begin
        m_pend = 1'b1;
        m_pq   = fq(a, b);
        m_pr   = fr(a, b);
        m_done = n + ((b == '0) ? ZLAT : LAT);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 100);
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input int elat, input string nm);
    int n;
    a = x;
    b = y;
    req = 1'b1;
    tick();
    req = 1'b0;
    a = ~x;
    b = y + 1;
    wait_ack(n);
    check({nm, "_lat"}, n, elat);
    check({nm, "_q"}, q, eq);
    check({nm, "_r"}, r, er);
  endtask

  int n;
  int k;
  int acks;

  initial begin
    repeat (3) tick();
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_ack", {31'b0, ack}, 0);
    rst = 1'b0;
    tick();

    do_op(11, 3, 3, 2, 33, "d11_3");
    repeat (35) tick();
    check("hold_q", q, 3);
    check("hold_r", r, 2);

    // back-to-back: second request lands in the DONE cycle
    a = 7; b = 2; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (W) tick();
    a = 7; b = 3; req = 1'b1;
    tick();
    req = 1'b0;
    check("b2b1_ack", {31'b0, ack}, 1);
    check("b2b1_q", q, 3);
    check("b2b1_r", r, 1);
    wait_ack(n);
    check("b2b2_lat", n, 33);
    check("b2b2_q", q, 2);
    check("b2b2_r", r, 1);

    do_op(123153, 2424, 50, 1953, 33, "d123153");
    do_op(5, 9, 0, 5, 33, "d5_9");
    do_op(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 33, "dmax_1");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 33, "dmax_max");
    do_op(0, 5, 0, 0, 33, "d0_5");
    do_op(42, 0, 32'hFFFF_FFFF, 42, ZLAT, "d42_0");

    // req held high restarts on every DONE
    a = 100; b = 7; req = 1'b1;
    tick();
    acks = 0;
    repeat (69) begin
      tick();
      if (ack) acks++;
    end
    req = 1'b0;
    check("cont_acks", acks, 2);
    wait_ack(n);
    check("cont_tail", n, 30);
    check("cont_q", q, 14);
    check("cont_r", r, 2);

    // req and new operands during RUN are ignored
    a = 1000; b = 7; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (5) tick();
    a = 3; b = 1; req = 1'b1;
    tick();
    req = 1'b0; a = 0; b = 0;
    wait_ack(n);
    k = 6 + n;
    check("ign_lat", k, 33);
    check("ign_q", q, 142);
    check("ign_r", r, 6);

    // reset at cycle 10 aborts; rst beats a simultaneous req
    a = 1000; b = 7; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (4) tick();
    a = 9; b = 2; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (4) tick();
    rst = 1'b1; req = 1'b1;
    tick();
    rst = 1'b0; req = 1'b0;
    acks = 0;
    repeat (40) begin
      tick();
      if (ack) acks++;
    end
    check("abort_acks", acks, 0);
    check("abort_q", q, 0);
    check("abort_r", r, 0);

    do_op(20, 6, 3, 2, 33, "post_rst");
    repeat (3) tick();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/int_div_pipeline_core.md
INT_DIV_PIPELINE_CORE -- requirements
Module: int_div_pipeline

Interface
REQ-001 Parameter: bitwidth, default 32, operand/result width in bits (>=2).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  1  start request; sampled on rising clk edge.
REQ-005 a  input  bitwidth  unsigned dividend; captured with accepted req.
REQ-006 b  input  bitwidth  unsigned divisor; captured with accepted req.
REQ-007 quotient  output  bitwidth  unsigned floor(a/b), registered.
REQ-008 remainder  output  bitwidth  unsigned a mod b, registered.
REQ-009 ack  output  1  one-cycle completion pulse, registered.

Function
REQ-010 The block SHALL implement unsigned iterative restoring division, one quotient bit per clock, MSB first.
REQ-011 The block SHALL use states IDLE, RUN, DONE: IDLE->RUN on req; RUN stays for bitwidth cycles then ->DONE; DONE->IDLE next cycle, or ->RUN if req is high that cycle.
REQ-012 The block SHALL accept req only in IDLE or DONE; req during RUN is ignored and does not alter the operation in progress.
REQ-013 The block SHALL capture a and b on the accepting edge; later changes on a/b have no effect on that operation.
REQ-014 Latency: ack SHALL be high exactly bitwidth+1 cycles after the accepting edge (33 cycles for bitwidth=32), for one cycle only.
REQ-015 quotient and remainder SHALL update only on the edge that raises ack, and SHALL hold that value until the next completion or reset.
REQ-016 Results SHALL satisfy a == quotient*b + remainder and remainder < b for every b != 0.
REQ-017 For a < b the block SHALL return quotient 0, remainder a.
REQ-018 For b == 0 the block SHALL return quotient all-ones and remainder a.
REQ-019 Internal partial remainder SHALL be bitwidth+1 bits wide so the trial subtraction cannot overflow.
REQ-020 req held high continuously SHALL start a new operation each time the block re-enters DONE.

Reset
REQ-021 While rst is high at a clk edge: state SHALL become IDLE, ack 0, quotient 0, remainder 0.
REQ-022 Reset during RUN SHALL abort the operation; no ack SHALL be produced for it.
REQ-023 rst SHALL take priority over req in the same cycle.

Configuration
REQ-024 Macro INT_DIV_ZERO_FAST_EN defined: b == 0 SHALL skip RUN and go directly to DONE, with ack high 1 cycle after the accepting edge and results per REQ-018.
REQ-025 Macro INT_DIV_ZERO_FAST_EN undefined: b == 0 SHALL run the normal bitwidth-cycle sequence and produce the REQ-018 results with REQ-014 latency.

Verification
REQ-026 a=11, b=3, 1-cycle req -> ack after 33 cycles; quotient 3, remainder 2; held 35 cycles later.
REQ-027 a=7, b=2 then a=7, b=3 back-to-back ops -> quotient 3/rem 1, then quotient 2/rem 1.
REQ-028 a=123153, b=2424 -> quotient 50, remainder 1953.
REQ-029 a=5, b=9 -> quotient 0, remainder 5; a=0xFFFFFFFF, b=1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-030 a=42, b=0 -> quotient 0xFFFFFFFF, remainder 42; ack at cycle 1 with INT_DIV_ZERO_FAST_EN, at cycle 33 without.
REQ-031 Assert rst at cycle 10 of an op; change a/b and pulse req during RUN -> no ack for aborted op; ignored req has no effect; outputs 0 after reset.
